// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator back end: score width, Q1.15
// limits, the argmax FSM state type and an elaboration-time clog2.
package cnn_pkg;

  localparam int DATA_W = 16;

  localparam logic [15:0] Q15_MIN = 16'h8000;
  localparam logic [15:0] Q15_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/argmax_snapshot_sreg.sv
// N-entry score snapshot: parallel load on start, then shifts toward the head
// one element per scan cycle so the scanner always reads a fixed tap.
module argmax_snapshot_sreg #(
  parameter int N      = 100,
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic [DATA_W*N-1:0] y_in,
  output logic [DATA_W-1:0]   head
);

  // Element 0 goes straight to the best register at load, so the scan
  // starts from entry 1 (entry 0 only exists as the tap when N == 1).
  localparam int unsigned HEAD = (N > 1) ? 1 : 0;

  logic [DATA_W-1:0] sreg [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) sreg[i] <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < N; i++) sreg[i] <= y_in[DATA_W*i +: DATA_W];
    end else if (shift) begin
      for (int unsigned i = 0; i + 1 < N; i++) sreg[i] <= sreg[i+1];
    end
  end

  assign head = sreg[HEAD];

endmodule

// File: rtl/dense_argmax.sv
// Final classification stage: snapshots the dense layer's score vector on
// start and scans it serially for the maximum signed Q1.15 score.
module dense_argmax #(
  parameter int N      = 100,
  parameter int IDX_W  = 7,
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W*N-1:0] y_in,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    class_idx,
  output logic [DATA_W-1:0]   max_val,
  output logic                result_valid
);

  import cnn_pkg::*;

  if (IDX_W < int'(clog2(N))) begin : g_idx_w_check
    $error("dense_argmax: IDX_W too small for N");
  end

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  argmax_state_t     state;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  best_idx;
  logic [DATA_W-1:0] best_val;
  logic [DATA_W-1:0] head;
  logic              load;
  logic              shift;

  assign load  = (state == IDLE) && start;
  assign shift = (state == SCAN);

  argmax_snapshot_sreg #(
    .N      (N),
    .DATA_W (DATA_W)
  ) u_snap (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .y_in  (y_in),
    .head  (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      best_idx     <= '0;
      best_val     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      class_idx    <= '0;
      max_val      <= '0;
      result_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            best_val <= y_in[DATA_W-1:0];
            best_idx <= '0;
            cnt      <= IDX_W'(1);
            busy     <= 1'b1;
            state    <= (N > 1) ? SCAN : DONE;
          end
        end
        SCAN: begin
          // Strictly greater only, so ties keep the lowest index.
          if ($signed(head) > $signed(best_val)) begin
            best_val <= head;
            best_idx <= cnt;
          end
          cnt <= cnt + IDX_W'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          class_idx    <= best_idx;
          max_val      <= best_val;
          done         <= 1'b1;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_argmax.sv
// Scoreboard bench for dense_argmax: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_dense_argmax;

  localparam int N      = 100;
  localparam int IDX_W  = 7;
  localparam int DATA_W = 16;

  logic                clk;
  logic                rst;
  logic [DATA_W*N-1:0] y_in;
  logic                start;
  logic                busy;
  logic                done;
  logic [IDX_W-1:0]    class_idx;
  logic [DATA_W-1:0]   max_val;
  logic                result_valid;

  dense_argmax #(
    .N      (N),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .y_in         (y_in),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .class_idx    (class_idx),
    .max_val      (max_val),
    .result_valid (result_valid)
  );

  typedef struct {
    int          idx;
    logic [15:0] val;
    int          cyc;
  } exp_t;

  exp_t                sb[$];
  int                  checks = 0;
  int                  passed = 0;
  int                  cyc    = 0;
  logic [DATA_W*N-1:0] vec;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("class_idx", 32'(class_idx), 32'(e.idx));
        chk("max_val", 32'(max_val), 32'(e.val));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("result_valid_at_done", 32'(result_valid), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic fill(input logic [15:0] v);
    for (int j = 0; j < N; j++) vec[16*j +: 16] = v;
  endtask

  task automatic setel(input int j, input logic [15:0] v);
    vec[16*j +: 16] = v;
  endtask

  // Returns with start already deasserted, #1 after the accepting edge T0.
  task automatic issue(input int eidx, input logic [15:0] evl, output int t0);
    exp_t e;
    @(negedge clk);
    y_in  = vec;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc;
    e.idx = eidx;
    e.val = evl;
    e.cyc = t0 + N;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < N + 20 && sb.size() != 0; i++) @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic run(input int eidx, input logic [15:0] evl);
    int t0;
    issue(eidx, evl, t0);
    drain();
  endtask

  task automatic quiet(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    exp_t e;
    rst   = 1'b1;
    start = 1'b0;
    y_in  = '0;
    vec   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_class_idx", 32'(class_idx), 32'd0);
    chk("rst_max_val", 32'(max_val), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ramp: element j = j
    for (int j = 0; j < N; j++) setel(j, 16'(j));
    issue(99, 16'd99, t0);
    chk("ramp_busy_t0", 32'(busy), 32'd1);
    chk("ramp_rv_before", 32'(result_valid), 32'd0);
    repeat (N - 1) @(posedge clk);
    #1;
    chk("ramp_busy_last", 32'(busy), 32'd1);
    chk("ramp_no_early_done", 32'(done), 32'd0);
    drain();

    // All zero, then a tie at 42 and 77
    fill(16'h0000);
    run(0, 16'h0000);
    setel(42, 16'd5);
    setel(77, 16'd5);
    run(42, 16'd5);

    // Negative scores
    fill(16'hFF9C);
    setel(37, 16'hFFFB);
    run(37, 16'hFFFB);
    fill(16'hFF9C);
    setel(0, 16'h8000);
    setel(99, 16'h7FFF);
    run(99, 16'h7FFF);
    fill(16'h8000);
    setel(0, 16'h7FFF);
    setel(50, 16'h7FFF);
    run(0, 16'h7FFF);

    // Snapshot isolation and start-while-busy
    fill(16'h0000);
    setel(3, 16'd7);
    issue(3, 16'd7, t0);
    repeat (1) @(posedge clk);
    #1;
    setel(10, 16'd1000);
    y_in = vec;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ignore_start", 32'(busy), 32'd1);
    drain();
    quiet(N + 20);

    // Back-to-back with start held high
    fill(16'h0000);
    setel(11, 16'd300);
    @(negedge clk);
    y_in  = vec;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    e.idx = 11; e.val = 16'd300; e.cyc = t0 + N;
    sb.push_back(e);
    fill(16'hFFFF);
    setel(88, 16'd2);
    y_in = vec;
    repeat (N + 1) @(posedge clk);
    #1;
    e.idx = 88; e.val = 16'd2; e.cyc = cyc + N;
    sb.push_back(e);
    fill(16'h1234);
    setel(60, 16'h4000);
    setel(61, 16'h4000);
    y_in = vec;
    repeat (N + 1) @(posedge clk);
    #1;
    start = 1'b0;
    e.idx = 60; e.val = 16'h4000; e.cyc = cyc + N;
    sb.push_back(e);
    drain();

    // Reset mid-scan
    for (int j = 0; j < N; j++) setel(j, 16'(N - j));
    @(negedge clk);
    y_in  = vec;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_class_idx", 32'(class_idx), 32'd0);
    chk("abort_max_val", 32'(max_val), 32'd0);
    chk("abort_result_valid", 32'(result_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    quiet(N + 20);
    run(0, 16'd100);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dense_argmax.md
Name: dense_argmax

Overview:
- Downstream consumer of the dense layer's packed output vector `y`: N signed Q1.15 scores (16 bits each).
- On a start pulse (driven from the dense layer's `resting` rising edge), snapshots the vector and scans it one element per cycle.
- Reports the winning class index and its score, plus a one-cycle done pulse.
- Final classification stage of the CNN accelerator.

Parameters:
- N, 100, number of scores in the input vector (equals dense parameter n); legal range 1..1024.
- IDX_W, 7, class index width; must satisfy 2**IDX_W >= N.
- DATA_W, 16, score width, signed Q1.15; fixed at 16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- y_in  input  DATA_W*N  packed scores; element j is y_in[DATA_W*(j+1)-1 -: DATA_W].
- start  input  1  request to classify the current y_in; sampled on a rising clk edge.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when class_idx/max_val become valid.
- class_idx  output  IDX_W  index of the maximum score.
- max_val  output  DATA_W  maximum score, signed.
- result_valid  output  1  sticky; high after the first completed scan.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE; busy, done, class_idx, max_val, result_valid, scan counter, best registers and snapshot all become 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - Triggered by start=1 at edge T0.
  - Snapshot y_in into an internal buffer.
  - best_val <= element 0; best_idx <= 0; cnt <= 1.
  - busy <= 1.
  - Next state is SCAN if N>1, else DONE.
- SCAN:
  - Each cycle compares snapshot[cnt] with best_val as signed values.
  - Update best only on strictly greater, so ties keep the lowest index.
  - cnt increments each cycle.
  - After processing cnt==N-1, go to DONE.
- DONE (one cycle):
  - class_idx <= best_idx; max_val <= best_val; done=1; result_valid <= 1; busy <= 0.
  - Return to IDLE.
- Latency: start sampled at T0, so done is high in the cycle after edge T0+N (N=100 gives done after edge T0+100).
  - For N=1, done follows edge T0+1.
- class_idx and max_val hold their values until the next DONE, so they are stable whenever done=0.
- start while busy (SCAN or DONE) is ignored; it is neither queued nor restarted.
- start in the same cycle the FSM returns to IDLE is accepted normally, giving back-to-back scans with a period of N+1 cycles.
- y_in changes after T0 do not affect the result because the snapshot is taken at T0.
- Comparison uses full 16-bit two's complement: 0x8000 is the minimum and 0x7FFF the maximum. No saturation or arithmetic is applied to the scores.
- Reset mid-scan aborts with no done pulse, and result_valid clears.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_W = 16 and the Q1.15 min/max constants (Q15_MIN = 16'h8000, Q15_MAX = 16'h7FFF);
  - the FSM state typedef (IDLE/SCAN/DONE);
  - a clog2 helper function.
- One natural sub-module, argmax_snapshot_sreg:
  - N-entry DATA_W shift register, parallel load on start, shifts one element toward its head per SCAN cycle;
  - avoids a wide N:1 mux.
- The compare/best registers and the FSM stay in dense_argmax.

Test Plan:
- Ramp: element j = j (0..99), start -> done after edge T0+100, class_idx=99, max_val=99, result_valid=1, busy high for cycles T0+1..T0+100.
- All zero: start -> class_idx=0, max_val=0 (tie keeps lowest index); then element 42=5 and element 77=5 -> class_idx=42, max_val=5.
- All negative: every element -100 (0xFF9C) except element 37 = -5 (0xFFFB) -> class_idx=37, max_val=0xFFFB. Also element 0=0x8000, element 99=0x7FFF -> class_idx=99, max_val=0x7FFF.
- Snapshot/busy: after start, overwrite y_in with element 10=1000 and pulse start at T0+5 -> result still from the original vector, exactly one done pulse, no restart.
- Back-to-back: start held high continuously -> done pulses every 101 cycles, each result matching the vector present at its own accepted start.
- Reset mid-scan: assert rst at T0+50 -> busy/done/class_idx/max_val/result_valid go to 0 immediately (asynchronous), no done pulse follows; a new start after release gives a correct result.
